// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and the signed add/sub overflow rule
// for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } alu_state_t;

  // Works on sign bits only so it is independent of the datapath width.
  function automatic logic add_sub_ovf(input logic sign_a, input logic sign_b,
                                       input logic sign_r, input logic is_sub);
    if (is_sub)
      return (sign_a != sign_b) && (sign_r != sign_a);
    else
      return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_iterative_unit.sv
// Unsigned shift-add multiplier / restoring divider, one bit per step.
// Outputs are the register values as they will be after the current step.
module alu_iterative_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               mode,      // 0: multiply, 1: divide
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient
);

  // hi/lo double as product halves (MUL) or remainder/dividend-quotient (DIV)
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             ge;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_shift = {hi, lo[WIDTH-1]};
    ge        = rem_shift >= {1'b0, opnd};
    rem_diff  = rem_shift[WIDTH-1:0] - opnd;
    if (mode) begin
      hi_n = ge ? rem_diff : rem_shift[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (load) begin
      hi   <= '0;
      lo   <= mode ? a_mag : b_mag;
      opnd <= mode ? b_mag : a_mag;
    end else if (step) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

  assign product  = {hi_n, lo_n};
  assign quotient = lo_n;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle logic/add/sub, WIDTH-cycle signed multiply
// and divide, start/busy/done handshake with held result and flags.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = $clog2(WIDTH+1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       selection,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] output_result,
  output logic             is_negative,
  output logic             is_zero,
  output logic             overflow,
  output logic             div_by_zero
);

  alu_state_t            state, state_next;
  logic [COUNT_BITS-1:0] count;
  logic                  neg_q;
  logic                  accept, load, step, last;
  logic [WIDTH-1:0]      x_mag, y_mag;
  logic [WIDTH-1:0]      sc_result;
  logic                  sc_ovf, sc_dbz;
  logic [2*WIDTH-1:0]    product, prod_s;
  logic [WIDTH-1:0]      quotient, quot_s;
  logic                  mul_ovf, div_ovf;

  assign busy   = (state != IDLE);
  assign accept = start && (state == IDLE);
  assign load   = accept && ((selection == OP_MUL) ||
                             ((selection == OP_DIV) && (y != '0)));
  assign step   = busy;
  assign last   = busy && (count == COUNT_BITS'(1));
  assign x_mag  = x[WIDTH-1] ? -x : x;
  assign y_mag  = y[WIDTH-1] ? -y : y;

  alu_iterative_unit #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .step     (step),
    .mode     (load ? (selection == OP_DIV) : (state == DIV)),
    .a_mag    (x_mag),
    .b_mag    (y_mag),
    .product  (product),
    .quotient (quotient)
  );

  // Only the most-negative / -1 case yields a positive quotient with the MSB set.
  always_comb begin
    prod_s  = neg_q ? -product : product;
    quot_s  = neg_q ? -quotient : quotient;
    mul_ovf = prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s[WIDTH-1]}};
    div_ovf = !neg_q && quotient[WIDTH-1];
  end

  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    case (selection)
      OP_PASS: sc_result = x;
      OP_ADD: begin
        sc_result = x + y;
        sc_ovf    = add_sub_ovf(x[WIDTH-1], y[WIDTH-1], sc_result[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        sc_result = x - y;
        sc_ovf    = add_sub_ovf(x[WIDTH-1], y[WIDTH-1], sc_result[WIDTH-1], 1'b1);
      end
      OP_AND:  sc_result = x & y;
      OP_OR:   sc_result = x | y;
      OP_DIV:  sc_dbz    = 1'b1;
      OP_NOT:  sc_result = ~x;
      default: sc_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = (selection == OP_MUL) ? MUL : DIV;
      MUL,
      DIV:     if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      neg_q <= 1'b0;
    end else if (load) begin
      count <= COUNT_BITS'(WIDTH);
      neg_q <= x[WIDTH-1] ^ y[WIDTH-1];
    end else if (step) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done          <= 1'b0;
      output_result <= '0;
      is_negative   <= 1'b0;
      is_zero       <= 1'b0;
      overflow      <= 1'b0;
      div_by_zero   <= 1'b0;
    end else if (accept && !load) begin
      done          <= 1'b1;
      output_result <= sc_result;
      is_negative   <= sc_result[WIDTH-1];
      is_zero       <= (sc_result == '0);
      overflow      <= sc_ovf;
      div_by_zero   <= sc_dbz;
    end else if (last) begin
      done          <= 1'b1;
      output_result <= (state == MUL) ? prod_s[WIDTH-1:0] : quot_s;
      is_negative   <= (state == MUL) ? prod_s[WIDTH-1] : quot_s[WIDTH-1];
      is_zero       <= (state == MUL) ? (prod_s[WIDTH-1:0] == '0) : (quot_s == '0);
      overflow      <= (state == MUL) ? mul_ovf : div_ovf;
      div_by_zero   <= 1'b0;
    end else begin
      done          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against a 64-bit arithmetic model.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   selection = '0;
  logic [W-1:0] x = '0, y = '0;
  logic         busy, done, is_negative, is_zero, overflow, div_by_zero;
  logic [W-1:0] output_result;

  int n_cmp = 0;
  int n_err = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .selection(selection),
    .x(x), .y(y), .busy(busy), .done(done), .output_result(output_result),
    .is_negative(is_negative), .is_zero(is_zero), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Returns {result, is_negative, is_zero, overflow, div_by_zero}.
  function automatic logic [W+3:0] model(input logic [2:0] s, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb, r, lim;
    logic [W-1:0] res;
    logic ovf, dbz;
    sa = $signed(a); sb = $signed(b);
    lim = longint'(1) << (W-1);
    r = 0; ovf = 0; dbz = 0;
    case (s)
      3'd0: r = sa;
      3'd1: r = sa + sb;
      3'd2: r = sa - sb;
      3'd3: r = longint'(a & b);
      3'd4: r = longint'(a | b);
      3'd5: r = sa * sb;
      3'd6: if (b == 0) dbz = 1; else r = sa / sb;
      default: r = longint'(~a);
    endcase
    if (s == 3'd1 || s == 3'd2 || s == 3'd5 || s == 3'd6)
      ovf = (r < -lim) || (r > lim - 1);
    res = r[W-1:0];
    return {res, res[W-1], res == 0, ovf, dbz};
  endfunction

  function automatic int exp_latency(input logic [2:0] s, input logic [W-1:0] b);
    return (s == 3'd5 || (s == 3'd6 && b != 0)) ? W + 1 : 1;
  endfunction

  // Issue one op and wait for done; x/y/selection are scrambled after issue.
  task automatic do_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bcnt);
    @(negedge clock);
    start = 1; selection = s; x = a; y = b;
    @(negedge clock);
    start = 0; selection = 3'($urandom); x = $urandom; y = $urandom;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    #12;
    n_cmp++;
    if ({busy, done, output_result, is_negative, is_zero, overflow, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h n=%b z=%b o=%b d=%b want all 0",
               busy, done, output_result, is_negative, is_zero, overflow, div_by_zero);
    end
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_directed();
    logic [2:0]   s  [12] = '{3'd1, 3'd1, 3'd2, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd2, 3'd0, 3'd7, 3'd5};
    logic [W-1:0] av [12] = '{32'd7, 32'h7FFFFFFF, 32'd5, -32'sd6, 32'h10000, -32'sd7,
                              32'h80000000, 32'd9, 32'h80000000, 32'h80000000, 32'h0,
                              32'h80000000};
    logic [W-1:0] bv [12] = '{-32'sd9, 32'd1, 32'd5, 32'd7, 32'h10000, 32'd2,
                              -32'sd1, 32'd0, 32'd1, 32'd3, 32'd5, -32'sd1};
    int lat, bcnt;
    logic [W+3:0] got, exp;
    for (int i = 0; i < 12; i++) begin
      do_op(s[i], av[i], bv[i], lat, bcnt);
      exp = model(s[i], av[i], bv[i]);
      got = {output_result, is_negative, is_zero, overflow, div_by_zero};
      n_cmp++;
      if (got !== exp || !done) begin
        n_err++;
        $display("FAIL directed_%0d: got {res,n,z,o,d}=%h done=%b want %h", i, got, done, exp);
      end
      n_cmp++;
      if (lat != exp_latency(s[i], bv[i]) || bcnt != exp_latency(s[i], bv[i]) - 1) begin
        n_err++;
        $display("FAIL latency_%0d: got lat=%0d busy=%0d want lat=%0d", i, lat, bcnt,
                 exp_latency(s[i], bv[i]));
      end
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse_%0d: got done=%b want 0", i, done);
      end
    end
    do_op(3'd1, 32'd7, -32'sd9, lat, bcnt);
    n_cmp++;
    if (output_result !== 32'hFFFFFFFE || is_negative !== 1'b1) begin
      n_err++;
      $display("FAIL add_const: got %h n=%b want fffffffe n=1", output_result, is_negative);
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    @(negedge clock);
    start = 1; selection = 3'd5; x = -32'sd6; y = 32'd7;
    for (int c = 1; c <= W + 6; c++) begin
      @(negedge clock);
      start = (c == 10);
      selection = (c == 10) ? 3'd1 : selection;
      if (done) dones++;
    end
    start = 0;
    n_cmp++;
    if (dones != 1 || output_result !== -32'sd42) begin
      n_err++;
      $display("FAIL busy_ignore: got dones=%0d res=%h want 1 and ffffffd6", dones, output_result);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    start = 1; selection = 3'd3; x = 32'hF0; y = 32'h3C;
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || output_result !== 32'h30) begin
      n_err++;
      $display("FAIL b2b_and: got done=%b res=%h want 1 00000030", done, output_result);
    end
    selection = 3'd4;
    @(negedge clock);
    start = 0;
    n_cmp++;
    if (done !== 1'b1 || output_result !== 32'hFC) begin
      n_err++;
      $display("FAIL b2b_or: got done=%b res=%h want 1 000000fc", done, output_result);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0 || output_result !== 32'hFC) begin
      n_err++;
      $display("FAIL b2b_hold: got done=%b res=%h want 0 000000fc", done, output_result);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones = 0, lat, bcnt;
    @(negedge clock);
    start = 1; selection = 3'd5; x = -32'sd6; y = 32'd7;
    @(negedge clock);
    start = 0;
    repeat (9) @(negedge clock);
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({busy, done, output_result, is_negative, is_zero, overflow, div_by_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b res=%h want all 0", busy, done, output_result);
    end
    @(negedge clock);
    reset_n = 1;
    repeat (W + 4) begin
      @(negedge clock);
      if (done) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_abort: got %0d done pulses want 0", dones);
    end
    do_op(3'd7, 32'd0, 32'd0, lat, bcnt);
    n_cmp++;
    if (output_result !== 32'hFFFFFFFF || is_negative !== 1'b1 || lat != 1) begin
      n_err++;
      $display("FAIL not_after_reset: got %h n=%b lat=%0d want ffffffff n=1 lat=1",
               output_result, is_negative, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic [2:0]   s;
    logic [W-1:0] a, b;
    logic [W+3:0] got, exp;
    int lat, bcnt;
    for (int i = 0; i < 60; i++) begin
      s = 3'($urandom_range(7));
      a = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
      b = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : $urandom;
      if ($urandom_range(1) == 0) b = b >> $urandom_range(31);
      do_op(s, a, b, lat, bcnt);
      exp = model(s, a, b);
      got = {output_result, is_negative, is_zero, overflow, div_by_zero};
      n_cmp++;
      if (got !== exp || lat != exp_latency(s, b)) begin
        n_err++;
        $display("FAIL random_%0d: op=%0d x=%h y=%h got %h lat=%0d want %h lat=%0d",
                 i, s, a, b, got, lat, exp, exp_latency(s, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the single-cycle ALU for the datapath core.
- Implements all eight opcodes. Logic ops run in one cycle; multiply and divide are iterative over WIDTH cycles.
- Issue uses a start/busy/done handshake; results and flags are held until the next accepted op.
- Adds overflow and divide-by-zero flags for the control unit's branch/exception logic.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
COUNT_BITS, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
selection  input  3  opcode, sampled with start
x  input  WIDTH  signed operand A, sampled with start
y  input  WIDTH  signed operand B, sampled with start
busy  output  1  iterative op in progress
done  output  1  one-cycle pulse: result/flags valid and updated
output_result  output  WIDTH  signed result, held until next done
is_negative  output  1  output_result[WIDTH-1]
is_zero  output  1  output_result == 0
overflow  output  1  signed overflow of last op
div_by_zero  output  1  last op was divide with y == 0

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0, state IDLE, counter 0. is_zero resets to 0, not derived.
  - Reset mid-operation aborts; no done is produced for the aborted op.
- Opcodes:
  - 000 pass x; 001 x+y; 010 x-y; 011 x&y; 100 x|y; 101 x*y; 110 x/y; 111 ~x.
- States: IDLE, MUL, DIV.
- Acceptance: start=1 and busy=0 at a rising edge (edge 0).
- Single-cycle ops (000-100, 111, and 110 with y==0):
  - Result and flags are registered at edge 0; done=1 during the following cycle.
  - State stays IDLE; busy stays 0.
  - A new start on the same cycle done=1 is accepted (back-to-back, 1 op/cycle).
- MUL, DIV:
  - At edge 0: enter MUL/DIV, busy=1. Latch |x|, |y| and the result sign. Counter=WIDTH.
  - One shift-add (MUL) or restoring shift-subtract (DIV) step per edge; counter decrements.
  - On the edge where counter reaches 0 (edge WIDTH):
    - Apply sign correction.
    - Update output_result/flags; return to IDLE.
    - busy=0 and done=1 in the next cycle.
  - Total latency: WIDTH cycles from acceptance to done. busy is high for WIDTH cycles.
- start while busy=1 is ignored and not queued.
- Outputs change only in the done cycle's preceding edge; they are stable otherwise.
- Arithmetic:
  - Two's complement; result is the low WIDTH bits.
  - Add overflow: operand signs equal and result sign differs.
  - Sub overflow: operand signs differ and result sign differs from x.
  - MUL overflow: the full 2*WIDTH signed product is not representable in WIDTH bits.
  - DIV: quotient truncates toward zero; remainder is discarded.
  - DIV of most-negative by -1: result = most-negative, overflow=1.
  - DIV y==0: result 0, div_by_zero=1, overflow=0, single-cycle.
  - overflow=0 for 000, 011, 100, 111. div_by_zero=0 for every op except 110 with y==0.
- Flags: is_negative/is_zero are recomputed from the registered result on every done.
- Unknown-free: no default branches produce X. All 8 codes are defined.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_PASS, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NOT;
  - the state enum: IDLE, MUL, DIV;
  - a function for the signed add/sub overflow check.
- Sub-module alu_iterative_unit(WIDTH) holds the unsigned shift-add/shift-subtract datapath:
  - inputs: magnitudes, mode, load, step;
  - outputs: 2*WIDTH product, quotient.
- The top level owns the FSM, sign handling, flags and handshake.

Test Plan:
- Add: x=7, y=-9, sel=001, start pulse -> next cycle done=1, output_result=-2, is_negative=1, is_zero=0, overflow=0.
- Add/sub edges:
  - x=0x7FFFFFFF, y=1, sel=001 -> 0x80000000, overflow=1.
  - x=5, y=5, sel=010 -> 0, is_zero=1.
- Mul: x=-6, y=7, sel=101 -> busy=1 for 32 cycles, done on cycle 33, result -42. Then:
  - start with sel=001 at cycle 10 is ignored (no extra done, result stays -42);
  - x=0x10000, y=0x10000 -> result 0, overflow=1.
- Div:
  - x=-7, y=2 -> -3 after 32 cycles;
  - x=0x80000000, y=-1 -> 0x80000000, overflow=1;
  - x=9, y=0 -> done next cycle, result 0, div_by_zero=1, is_zero=1.
- Reset during MUL at cycle 10 (reset_n low mid-cycle) -> outputs immediately 0, busy=0, no done. After release, sel=111, x=0 -> result 0xFFFFFFFF, is_negative=1.
- Back-to-back single-cycle ops on consecutive cycles (AND 0xF0&0x3C, then OR) -> done high two cycles, results 0x30 then 0xFC.
